if_stage: RTL and testbench

//  Instruction-fetch stage of the pipelined MIPS core; sits directly upstream of the instruction ROM.

---
 rtl/if_stage_if.sv | 27 ++
 rtl/if_stage.sv | 104 ++++++++++
 tb/tb_if_stage.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage bus: ROM word port plus the IF/ID handshake toward decode.
// master = fetch stage, slave = the ROM/decode side that consumes it.
interface if_stage_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] o_rom_addr;
  logic [31:0]           i_rom_data;
  logic                  i_ready;
  logic                  i_flush;
  logic                  i_branch_taken;
  logic [31:0]           i_branch_target;
  logic                  o_valid;
  logic [31:0]           o_instr;
  logic [31:0]           o_pc;
  logic [31:0]           o_pc_plus4;
  logic                  o_halted;

  modport master (
    output o_rom_addr, o_valid, o_instr, o_pc, o_pc_plus4, o_halted,
    input  i_rom_data, i_ready, i_flush, i_branch_taken, i_branch_target
  );

  modport slave (
    input  o_rom_addr, o_valid, o_instr, o_pc, o_pc_plus4, o_halted,
    output i_rom_data, i_ready, i_flush, i_branch_taken, i_branch_target
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the ROM, fills the IF/ID register.
// Optional build macro IF_PERF_CNT_EN adds fetch/bubble performance counters.
module if_stage #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  if_stage_if.master  bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_pc_plus4_q;

  logic [31:0] target_w;
  logic        pc_in_range;
  logic        target_in_range;
  logic        ld;

  assign target_w        = {bus.i_branch_target[31:2], 2'b00};
  // Anything above the ROM window, including a wrapped PC, halts instead of fetching.
  assign pc_in_range     = (pc_q[31:ADDR_WIDTH+2] == '0);
  assign target_in_range = (target_w[31:ADDR_WIDTH+2] == '0);
  assign ld              = (state_q == RUN) && (!valid_q || bus.i_ready);

  assign bus.o_rom_addr  = pc_q[ADDR_WIDTH+1:2];
  assign bus.o_valid     = valid_q;
  assign bus.o_instr     = instr_q;
  assign bus.o_pc        = id_pc_q;
  assign bus.o_pc_plus4  = id_pc_plus4_q;
  assign bus.o_halted    = (state_q == HALT);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      valid_q       <= 1'b0;
      instr_q       <= '0;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (bus.i_branch_taken) begin
            pc_q    <= target_w;
            valid_q <= 1'b0;
          end else if (bus.i_flush) begin
            valid_q <= 1'b0;
          end else if (ld) begin
            if (pc_in_range) begin
              instr_q       <= bus.i_rom_data;
              id_pc_q       <= pc_q;
              id_pc_plus4_q <= pc_q + 32'd4;
              valid_q       <= 1'b1;
              pc_q          <= pc_q + 32'd4;
            end else begin
              state_q <= HALT;
              valid_q <= 1'b0;
            end
          end
        end
        HALT: begin
          // Only a redirect into the ROM window restarts fetching.
          if (bus.i_branch_taken) begin
            pc_q    <= target_w;
            valid_q <= 1'b0;
            if (target_in_range) state_q <= RUN;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fetch_cnt  <= '0;
      o_bubble_cnt <= '0;
    end else begin
      if (valid_q && bus.i_ready)         o_fetch_cnt  <= o_fetch_cnt + 32'd1;
      if ((state_q == RUN) && !valid_q)   o_bubble_cnt <= o_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage against a ROM whose word i holds 32'h1000_0000+i.
// Build with +define+IF_PERF_CNT_EN to also cover the performance counters.
module tb_if_stage;

  localparam int AW = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  if_stage_if #(.ADDR_WIDTH(AW)) bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  if_stage #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.master)
`ifdef IF_PERF_CNT_EN
    ,
    .o_fetch_cnt  (fetch_cnt),
    .o_bubble_cnt (bubble_cnt)
`endif
  );

  assign bus.i_rom_data = 32'h1000_0000 + {{(32-AW){1'b0}}, bus.o_rom_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr);
    check({tag, ".valid"}, {31'b0, bus.o_valid}, {31'b0, v});
    check({tag, ".pc"}, bus.o_pc, pc);
    check({tag, ".instr"}, bus.o_instr, instr);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.i_ready         = 1'b1;
    bus.i_flush         = 1'b0;
    bus.i_branch_taken  = 1'b0;
    bus.i_branch_target = 32'h0;
    #12;
    check_if("rst", 1'b0, 32'h0, 32'h0);
    check("rst.plus4", bus.o_pc_plus4, 32'h0);
    check("rst.halted", {31'b0, bus.o_halted}, 32'h0);
    check("rst.addr", {24'b0, bus.o_rom_addr}, 32'h0);
    rst_n = 1'b1;

    // Test 1: BOOT cycle, then back-to-back fetches
    tick();
    check("boot.valid", {31'b0, bus.o_valid}, 32'h0);
    tick();
    check_if("t1.first", 1'b1, 32'h0, 32'h1000_0000);
    check("t1.plus4", bus.o_pc_plus4, 32'h4);
    tick();
    check_if("t1.pc4", 1'b1, 32'h4, 32'h1000_0001);
    tick();
    check_if("t1.pc8", 1'b1, 32'h8, 32'h1000_0002);

    // Test 2: stall for three clocks while o_pc=8
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_if("t2.stall", 1'b1, 32'h8, 32'h1000_0002);
      check("t2.addr", {24'b0, bus.o_rom_addr}, 32'h3);
    end
    bus.i_ready = 1'b1;
    tick();
    check_if("t2.resume", 1'b1, 32'hC, 32'h1000_0003);
    for (int i = 0; i < 7; i++) tick();
    check_if("t1.run", 1'b1, 32'h28, 32'h1000_000A);
`ifdef IF_PERF_CNT_EN
    check("perf.fetch10", fetch_cnt, 32'd10);
    check("perf.bubble", bubble_cnt, 32'd1);
`endif

    // Test 3: redirect to an unaligned target
    bus.i_branch_taken  = 1'b1;
    bus.i_branch_target = 32'h0000_0043;
    tick();
    bus.i_branch_taken = 1'b0;
    check("t3.bubble", {31'b0, bus.o_valid}, 32'h0);
    check("t3.addr", {24'b0, bus.o_rom_addr}, 32'h10);
    tick();
    check_if("t3.target", 1'b1, 32'h40, 32'h1000_0010);
    check("t3.plus4", bus.o_pc_plus4, 32'h44);

    // Test 4: flush and branch together, then flush alone
    bus.i_flush         = 1'b1;
    bus.i_branch_taken  = 1'b1;
    bus.i_branch_target = 32'h20;
    tick();
    bus.i_flush        = 1'b0;
    bus.i_branch_taken = 1'b0;
    check("t4.bubble", {31'b0, bus.o_valid}, 32'h0);
    tick();
    check_if("t4.target", 1'b1, 32'h20, 32'h1000_0008);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    check_if("t4.flush", 1'b0, 32'h20, 32'h1000_0008);
    check("t4.hold", {24'b0, bus.o_rom_addr}, 32'h9);
    tick();
    check_if("t4.after", 1'b1, 32'h24, 32'h1000_0009);

    // Test 5: last ROM word, out-of-range halt, restart
    bus.i_branch_taken  = 1'b1;
    bus.i_branch_target = 32'h3FC;
    tick();
    bus.i_branch_taken = 1'b0;
    tick();
    check_if("t5.last", 1'b1, 32'h3FC, 32'h1000_00FF);
    tick();
    check("t5.halted", {31'b0, bus.o_halted}, 32'h1);
    check("t5.valid", {31'b0, bus.o_valid}, 32'h0);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    check("t5.flushhalt", {31'b0, bus.o_halted}, 32'h1);
    bus.i_branch_taken  = 1'b1;
    bus.i_branch_target = 32'hFFFF_FFFF;
    tick();
    check("t5.highhalt", {31'b0, bus.o_halted}, 32'h1);
    check("t5.highaddr", {24'b0, bus.o_rom_addr}, 32'hFF);
    bus.i_branch_target = 32'h0;
    tick();
    bus.i_branch_taken = 1'b0;
    check("t5.resume", {31'b0, bus.o_halted}, 32'h0);
    check("t5.bubble", {31'b0, bus.o_valid}, 32'h0);
    tick();
    check_if("t5.pc0", 1'b1, 32'h0, 32'h1000_0000);
    tick();
    check_if("t5.pc4", 1'b1, 32'h4, 32'h1000_0001);

    // Test 6: asynchronous reset in the middle of a stall
    bus.i_ready = 1'b0;
    tick();
    check_if("t6.stall", 1'b1, 32'h4, 32'h1000_0001);
    #2;
    rst_n = 1'b0;
    #1;
    check_if("t6.rst", 1'b0, 32'h0, 32'h0);
    check("t6.halted", {31'b0, bus.o_halted}, 32'h0);
    check("t6.addr", {24'b0, bus.o_rom_addr}, 32'h0);
`ifdef IF_PERF_CNT_EN
    check("t6.fetch", fetch_cnt, 32'h0);
    check("t6.bubble", bubble_cnt, 32'h0);
`endif
    tick();
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
